// File: rtl/cpu_readback_responder_pkg.sv
// Shared readback window offsets and responder FSM states.
// The controller and the host-side map both reference these constants.
package cpu_readback_responder_pkg;

  localparam logic [2:0] OFF_STATUS  = 3'd0;
  localparam logic [2:0] OFF_TIME0   = 3'd1;
  localparam logic [2:0] OFF_TIME1   = 3'd2;
  localparam logic [2:0] OFF_TIME2   = 3'd3;
  localparam logic [2:0] OFF_TIME3   = 3'd4;
  localparam logic [2:0] OFF_VERSION = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_TURN  = 2'd3
  } rb_state_e;

  function automatic logic [15:0] status_word(input logic thermo, input logic sticky,
                                              input logic snap_vld, input logic [7:0] cnt);
    return {cnt, 5'b0, snap_vld, sticky, thermo};
  endfunction

endpackage

// File: rtl/cpu_readback_responder_sync2.sv
// Generic 2-flop level synchroniser into the CLK domain.
// Latency: two CLK edges; no flow control.
module cpu_readback_responder_sync2 #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_readback_responder.sv
// CPU read responder: status, coherent 64-bit time snapshot, version, unmapped-read counter.
// Latency: READ_LATENCY+1 edges from hit to drive; no backpressure, drive held while EN & RD.
module cpu_readback_responder
  import cpu_readback_responder_pkg::*;
#(
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] VERSION      = 16'h0022,
  parameter logic [1:0]  SELECT_ID    = 2'b00,
  parameter logic [13:0] BASE_ADDR    = 14'h0100
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        RD,
  input  logic        RDWR,
  input  logic        WE,
  input  logic [1:0]  BRAM_SELECT,
  input  logic [13:0] BRAM_ADDR,
  input  logic [63:0] SYS_TIME,
  input  logic        THERMO,
  input  logic        WDT_ASSERT,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        BUSY
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

  rb_state_e   state_q, state_d;
  logic [2:0]  off_q, lat_cnt_q;
  logic [63:0] snap_q;
  logic        snap_vld_q, wdt_sticky_q, wdt_prev_q;
  logic [7:0]  unmapped_q;
  logic        thermo_s, wdt_s, wdt_rise;
  logic        hit, abort;
  logic        accept, load_drive, exit_drive, status_exit;
  logic [15:0] read_word;

  cpu_readback_responder_sync2 #(.W(1)) u_sync_thermo (
    .CLK(CLK), .RST_N(RST_N), .d(THERMO), .q(thermo_s)
  );

  cpu_readback_responder_sync2 #(.W(1)) u_sync_wdt (
    .CLK(CLK), .RST_N(RST_N), .d(WDT_ASSERT), .q(wdt_s)
  );

  assign hit = EN & RD & RDWR & ~WE & (BRAM_SELECT == SELECT_ID)
             & (BRAM_ADDR[13:3] == BASE_ADDR[13:3]);
  assign abort    = ~EN | ~RD | WE;
  assign wdt_rise = wdt_s & ~wdt_prev_q;
  assign BUSY     = (state_q != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hit) state_d = ST_WAIT;
      ST_WAIT: begin
        if (abort)                 state_d = ST_TURN;
        else if (lat_cnt_q == 3'd0) state_d = ST_DRIVE;
      end
      ST_DRIVE: if (abort) state_d = ST_TURN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept      = (state_q == ST_IDLE) & hit;
    load_drive  = (state_q == ST_WAIT) & ~abort & (lat_cnt_q == 3'd0);
    exit_drive  = (state_q == ST_DRIVE) & abort;
    status_exit = exit_drive & (off_q == OFF_STATUS);
  end

  // Word 1 reads live time; words 2-4 come only from the snapshot so a 1..4 sweep is coherent.
  always_comb begin
    read_word = 16'h0000;
    case (off_q)
      OFF_STATUS:  read_word = status_word(thermo_s, wdt_sticky_q, snap_vld_q, unmapped_q);
      OFF_TIME0:   read_word = SYS_TIME[15:0];
      OFF_TIME1:   read_word = snap_q[31:16];
      OFF_TIME2:   read_word = snap_q[47:32];
      OFF_TIME3:   read_word = snap_q[63:48];
      OFF_VERSION: read_word = VERSION;
      default:     read_word = 16'h0000;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      off_q        <= '0;
      lat_cnt_q    <= '0;
      DATA_OUT     <= '0;
      DATA_OE      <= 1'b0;
      snap_q       <= '0;
      snap_vld_q   <= 1'b0;
      unmapped_q   <= '0;
      wdt_sticky_q <= 1'b0;
      wdt_prev_q   <= 1'b0;
    end else begin
      wdt_prev_q <= wdt_s;
      if (accept) begin
        off_q     <= BRAM_ADDR[2:0];
        lat_cnt_q <= LAT_INIT;
      end else if (state_q == ST_WAIT && lat_cnt_q != 3'd0) begin
        lat_cnt_q <= lat_cnt_q - 3'd1;
      end
      if (load_drive) begin
        DATA_OUT <= read_word;
        DATA_OE  <= 1'b1;
      end else if (exit_drive) begin
        DATA_OE <= 1'b0;
      end
      if (load_drive && off_q == OFF_TIME0) begin
        snap_q     <= SYS_TIME;
        snap_vld_q <= 1'b1;
      end
      if (load_drive && off_q[2:1] == 2'b11 && unmapped_q != 8'hFF)
        unmapped_q <= unmapped_q + 8'd1;
      else if (status_exit)
        unmapped_q <= 8'h00;
      // A watchdog edge landing on the STATUS exit cycle must not be lost.
      if (wdt_rise)         wdt_sticky_q <= 1'b1;
      else if (status_exit) wdt_sticky_q <= 1'b0;
    end
  end

endmodule
